// File: rtl/spi_slave_link.sv
// SPI mode-0 slave endpoint, MSB first, oversampled in the clk domain.
// SCLK/SS_n/MOSI are synchronized and SCLK edges are detected locally.
// Received words leave on a pulse interface. Transmit words come from a
// small FIFO and are shifted out on MISO.
// Ports:
//   clk, rst             system clock, async active-high reset
//   SCLK, SS_n, MOSI     SPI pins from the master (asynchronous)
//   MISO                 registered slave-out data
//   tx_data/valid/ready  TX FIFO push interface
//   rx_data, rx_valid    last received word, one-clk update pulse
//   frame_active         high while synchronized SS_n is low
//   tx_underrun          pulse when IDLE_WORD is loaded from an empty FIFO
module spi_slave_link #(
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter int unsigned       TX_DEPTH    = 4,
   parameter logic [DATA_W-1:0] IDLE_WORD   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCLK,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_active,
   output logic              tx_underrun
);

   localparam int unsigned PTR_W = $clog2(TX_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned BIT_W = $clog2(DATA_W + 1);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
   logic                   sclk_d;
   logic [BIT_W-1:0]       bit_cnt;
   logic [DATA_W-1:0]      rx_shift, tx_shift;
   logic                   rx_done;
   logic [DATA_W-1:0]      mem [TX_DEPTH];
   logic [PTR_W-1:0]       rd_ptr, wr_ptr;
   logic [CNT_W-1:0]       count, count_nxt;

   logic sclk_s, ss_s, mosi_s;
   logic enter, leave, in_frame, rise, fall, load, fifo_empty, push, pop;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Frame transitions take priority over any SCLK edge seen in the same clk
   always_comb begin
      enter      = (state == ST_IDLE) && !ss_s;
      leave      = (state == ST_ACTIVE) && ss_s;
      in_frame   = (state == ST_ACTIVE) && !ss_s;
      rise       = in_frame && sclk_s && !sclk_d;
      fall       = in_frame && !sclk_s && sclk_d;
      load       = enter || (fall && (bit_cnt == '0));
      fifo_empty = (count == '0);
      push       = tx_valid && tx_ready;
      pop        = load && !fifo_empty;
      count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
   end

   // FIFO storage needs no reset; occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   // Synchronizers, FIFO pointers, frame FSM and shift registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync    <= '0;
         ss_sync      <= '1;
         mosi_sync    <= '0;
         sclk_d       <= 1'b0;
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         rx_shift     <= '0;
         tx_shift     <= '0;
         rx_done      <= 1'b0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         tx_ready     <= 1'b1;
         MISO         <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_active <= 1'b0;
         tx_underrun  <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sclk_d    <= sclk_s;

         // Completed word is published one clk after its last bit
         rx_done  <= 1'b0;
         rx_valid <= rx_done;
         if (rx_done) rx_data <= rx_shift;

         tx_underrun <= load && fifo_empty;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count    <= count_nxt;
         tx_ready <= (count_nxt != CNT_W'(TX_DEPTH));

         case (state)
            ST_IDLE: begin
               MISO <= 1'b0;
               if (enter) begin
                  state        <= ST_ACTIVE;
                  frame_active <= 1'b1;
                  bit_cnt      <= '0;
                  tx_shift     <= fifo_empty ? IDLE_WORD : mem[rd_ptr];
               end
            end
            ST_ACTIVE: begin
               if (leave) begin
                  // Partial words in either direction are dropped
                  state        <= ST_IDLE;
                  frame_active <= 1'b0;
                  bit_cnt      <= '0;
                  MISO         <= 1'b0;
               end else begin
                  MISO <= tx_shift[DATA_W-1];
                  if (rise) begin
                     rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                     if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        bit_cnt <= '0;
                        rx_done <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                     end
                  end
                  if (fall) begin
                     if (bit_cnt == '0)
                        tx_shift <= fifo_empty ? IDLE_WORD : mem[rd_ptr];
                     else
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_link.sv
// Scoreboard bench for spi_slave_link: a behavioural SPI master drives the
// pins, expected RX and MISO words are queued by the stimulus, and a monitor
// compares them as the DUT / master produce them.
module tb_spi_slave_link;

   localparam int H = 80;   // SCLK half period in ns (SCLK = clk/16)

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       SCLK = 1'b0;
   logic       SS_n = 1'b1;
   logic       MOSI = 1'b0;
   logic       MISO;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_active;
   logic       tx_underrun;

   int checks = 0;
   int errors = 0;
   int underrun_cnt = 0;

   logic [7:0] exp_rx[$];
   logic [7:0] exp_miso[$];
   logic [7:0] miso_got[$];
   logic [7:0] fill_words [5];

   spi_slave_link #(.DATA_W(8), .SYNC_STAGES(2), .TX_DEPTH(4), .IDLE_WORD(8'h00)) dut (
      .clk(clk), .rst(rst), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_active(frame_active),
      .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: RX words, MISO words seen by the master, underrun pulses
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            if (exp_rx.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
         end
         if (tx_underrun) underrun_cnt++;
      end
      while (miso_got.size() > 0) begin
         if (exp_miso.size() == 0) check("miso_unexpected", 32'(miso_got.pop_front()), 32'hFFFF_FFFF);
         else check("miso_word", 32'(miso_got.pop_front()), 32'(exp_miso.pop_front()));
      end
   end

   // Master shifts nbits of data MSB first. SS_n rises while SCLK is still high
   // so the trailing fall lands outside the frame.
   task automatic spi_xfer(input int nbits, input logic [31:0] data);
      logic [7:0] acc;
      int k;
      acc = 8'h00;
      k = 0;
      SS_n = 1'b0;
      #(H);
      check("frame_active_on", 32'(frame_active), 32'd1);
      for (int i = 0; i < nbits; i++) begin
         if (i > 0) SCLK = 1'b0;
         MOSI = data[nbits-1-i];
         #(H);
         SCLK = 1'b1;
         acc = {acc[6:0], MISO};
         k++;
         if (k == 8) begin
            miso_got.push_back(acc);
            k = 0;
         end
         #(H);
      end
      SS_n = 1'b1;
      #(H);
      SCLK = 1'b0;
      check("frame_active_off", 32'(frame_active), 32'd0);
      #(4*H);
   endtask

   task automatic push_word(input logic [7:0] w);
      @(negedge clk);
      check("tx_ready_before_push", 32'(tx_ready), 32'd1);
      tx_data  = w;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      fill_words[0] = 8'h5B; fill_words[1] = 8'hC6; fill_words[2] = 8'h29;
      fill_words[3] = 8'h74; fill_words[4] = 8'hEE;

      // Reset values
      #23;
      check("rst_miso", 32'(MISO), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_frame_active", 32'(frame_active), 32'd0);
      check("rst_tx_underrun", 32'(tx_underrun), 32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (4) @(posedge clk);

      // 1: single word
      push_word(8'hA5);
      exp_miso.push_back(8'hA5);
      exp_rx.push_back(8'h3C);
      spi_xfer(8, 32'h3C);
      check("t1_underrun", 32'(underrun_cnt), 32'd0);

      // 2: three gapless words in one frame
      push_word(8'h11); push_word(8'h22); push_word(8'h33);
      exp_miso.push_back(8'h11); exp_miso.push_back(8'h22); exp_miso.push_back(8'h33);
      exp_rx.push_back(8'hDE); exp_rx.push_back(8'hAD); exp_rx.push_back(8'hBE);
      spi_xfer(24, 32'hDEADBE);
      check("t2_underrun", 32'(underrun_cnt), 32'd0);

      // 3: empty FIFO gives IDLE_WORD and one underrun
      exp_miso.push_back(8'h00);
      exp_rx.push_back(8'hFF);
      spi_xfer(8, 32'hFF);
      check("t3_underrun", 32'(underrun_cnt), 32'd1);

      // 4: fill FIFO with tx_valid held, fifth word refused
      @(negedge clk);
      tx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tx_data = fill_words[i];
         @(posedge clk);
         #1;
         if (i == 3) check("t4_full_after_4", 32'(tx_ready), 32'd0);
      end
      repeat (2) @(posedge clk);
      #1 check("t4_still_full", 32'(tx_ready), 32'd0);
      tx_valid = 1'b0;
      exp_miso.push_back(8'h5B);
      exp_rx.push_back(8'h42);
      spi_xfer(8, 32'h42);
      check("t4_ready_after_pop", 32'(tx_ready), 32'd1);

      // 5: aborted 5-bit frame, then full frame
      spi_xfer(5, 32'h1F);
      exp_miso.push_back(8'h29);
      exp_rx.push_back(8'h81);
      spi_xfer(8, 32'h81);
      check("t5_underrun", 32'(underrun_cnt), 32'd1);

      // 6: reset mid-frame after 3 bits
      push_word(8'h5A);
      SS_n = 1'b0;
      #(H);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) SCLK = 1'b0;
         MOSI = 1'b1;
         #(H);
         SCLK = 1'b1;
         #(H);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_miso", 32'(MISO), 32'd0);
      check("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
      check("t6_rst_tx_ready", 32'(tx_ready), 32'd1);
      check("t6_rst_frame_active", 32'(frame_active), 32'd0);
      SS_n = 1'b1;
      SCLK = 1'b0;
      MOSI = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      repeat (4) @(posedge clk);
      exp_miso.push_back(8'h00);
      exp_rx.push_back(8'hC3);
      spi_xfer(8, 32'hC3);
      check("t6_underrun_empty_fifo", 32'(underrun_cnt), 32'd2);

      #(4*H);
      check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
      check("miso_queue_drained", 32'(exp_miso.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_link.md
Name: spi_slave_link

Overview:
SPI slave endpoint that terminates the link driven by the SPI master, on the other FPGA or as the loopback partner in simulation. It oversamples SCLK/SS_n/MOSI in the local clk domain and runs SPI mode 0 (CPOL=0, CPHA=0), MSB first. Received bytes go out on a pulse interface. Transmit bytes are fed through a small FIFO and shifted out on MISO.

Parameters:
DATA_W, 8, bits per SPI word
SYNC_STAGES, 2, synchronizer flops on SCLK, SS_n and MOSI (>=2)
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
IDLE_WORD, 8'h00, word shifted out when the TX FIFO is empty at load time

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst  in  1  asynchronous, active-high reset
SCLK  in  1  SPI clock from master; asynchronous to clk
SS_n  in  1  active-low slave select from master
MOSI  in  1  master-out data
MISO  out  1  slave-out data; registered
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  FIFO not full; a push occurs when tx_valid && tx_ready
rx_data  out  DATA_W  last complete received word; held until the next word completes
rx_valid  out  1  one-clk pulse when rx_data updates
frame_active  out  1  high while synchronized SS_n is low
tx_underrun  out  1  one-clk pulse when IDLE_WORD is loaded because the FIFO is empty

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: MISO=0, rx_data=0, rx_valid=0, frame_active=0, tx_underrun=0. FIFO is empty and tx_ready=1. SCLK and MOSI synchronizers reset to 0, SS_n synchronizer to 1. Bit counter=0. State=IDLE.
- Rate limit: SCLK frequency must be <= clk/8. Edges are detected from the last two synchronized SCLK samples.
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE on synchronized SS_n falling.
  - ACTIVE -> IDLE on synchronized SS_n rising.
- Entering ACTIVE:
  - Pop the FIFO head into the TX shift register, or load IDLE_WORD and pulse tx_underrun if the FIFO is empty.
  - Drive the shift register MSB on MISO on the next clk.
  - Clear the bit counter.
  - First MISO bit is valid SYNC_STAGES+2 clks after the SS_n pin falls.
- Detected SCLK rise (ACTIVE only):
  - Shift synchronized MOSI into the RX shift register LSB.
  - Increment the bit counter.
  - When the counter reaches DATA_W: on the next clk, rx_data takes the assembled word and rx_valid pulses for 1 clk; the counter wraps to 0.
- Detected SCLK fall (ACTIVE only):
  - Counter != 0: shift TX left and present the next bit on MISO.
  - Counter == 0 (word boundary): load the next word (pop, or IDLE_WORD + tx_underrun) and present its MSB. Back-to-back words within one frame are therefore gapless.
- SS_n rising mid-word: discard the partial RX word (no rx_valid) and clear the counter. The partially sent TX word is lost and is not re-queued. MISO goes to 0.
- IDLE: MISO=0. SCLK edges are ignored.
- FIFO:
  - tx_ready = !full, registered from the count.
  - Push and pop in the same clk: count unchanged, both take effect.
  - When full, a pop does not raise tx_ready until the following clk.
  - A push into an empty FIFO in the same clk as a load does not bypass: IDLE_WORD is loaded and the pushed word stays queued.
- rx has no backpressure. The consumer must accept each rx_valid pulse.
- SS_n falling and SCLK rise detected in the same clk: protocol violation. The SS_n transition takes priority and the SCLK edge is ignored.

Test Plan:
1. Reset, then push 8'hA5. Master sends 8'h3C in one frame. Required: MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid high exactly 1 clk; tx_underrun never pulses.
2. Push 8'h11, 8'h22, 8'h33. Master sends a 3-word frame 8'hDE, 8'hAD, 8'hBE. Required: MISO carries 11,22,33 gaplessly; three rx_valid pulses with DE, AD, BE; FIFO ends empty.
3. FIFO empty when SS_n falls, master sends 8'hFF. Required: MISO = 8'h00 (IDLE_WORD); tx_underrun pulses once; rx_data=8'hFF.
4. Push 4 words with tx_valid held high. Required: tx_ready=0 after the 4th push and a 5th word is not accepted. After one word is shifted out in a frame, tx_ready=1 again.
5. Master raises SS_n after 5 SCLK cycles, then runs a full frame sending 8'h81. Required: no rx_valid for the partial word; next rx_data=8'h81; the partial TX word is consumed from the FIFO.
6. Assert rst mid-frame (after 3 bits). Required: MISO=0, rx_valid=0, FIFO empty, tx_ready=1 immediately (asynchronously). The next full frame receives correctly.
